// File: rtl/pwm_canon_voices.sv
// Round (canon) player: a beat prescaler drives a per-beat note fetch for each voice,
// each voice runs a square-wave divider, and a PWM mixer outputs the summed squares.
module pwm_canon_voices #(
    parameter int unsigned VOICES      = 3,
    parameter int unsigned OFFSET      = 8,
    parameter int unsigned DIV_BITS    = 10,
    parameter int unsigned PWM_BITS    = 8,
    parameter int unsigned BEAT_CYCLES = 3000000,
    parameter int unsigned FAST_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fast_start,
    output logic [6:0]          note_addr,
    input  logic [DIV_BITS-1:0] note_div,
    output logic [6:0]          crotchet,
    output logic [DIV_BITS-1:0] low_count,
    output logic [VOICES-1:0]   voice_active,
    output logic                pwm
);
    localparam int unsigned MAX_CYCLES = (BEAT_CYCLES > FAST_CYCLES) ? BEAT_CYCLES : FAST_CYCLES;
    localparam int unsigned PS_BITS    = $clog2(MAX_CYCLES);
    localparam int unsigned VB         = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam int unsigned NB         = $clog2(VOICES + 1);
    localparam int unsigned STEP       = ((2 ** PWM_BITS) - 1) / VOICES;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t                state;
    logic [VB-1:0]         voice;
    logic                  boot;
    logic                  looped;
    logic [PS_BITS-1:0]    prescale;
    logic [PS_BITS-1:0]    period_m1;
    logic                  beat_tick;
    int unsigned           voice_base;
    logic                  fetch_active;
    logic [DIV_BITS-1:0]   div [VOICES];
    logic [DIV_BITS-1:0]   cnt [VOICES];
    logic [VOICES-1:0]     sq;
    logic [NB-1:0]         ones;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic [PWM_BITS-1:0]   level;

    always_comb begin
        period_m1    = fast_start ? PS_BITS'(FAST_CYCLES - 1) : PS_BITS'(BEAT_CYCLES - 1);
        beat_tick    = (prescale >= period_m1);
        voice_base   = 32'(voice) * OFFSET;
        fetch_active = looped || (32'(crotchet) >= voice_base);
        note_addr    = (state == FETCH) ? (crotchet - 7'(voice_base)) : '0;
    end

    // boot forces one fetch on the first edge out of reset so voice 0 sounds immediately.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescale     <= '0;
            crotchet     <= '0;
            looped       <= 1'b0;
            state        <= IDLE;
            voice        <= '0;
            boot         <= 1'b1;
            voice_active <= '0;
            for (int unsigned i = 0; i < VOICES; i++) begin
                div[i] <= '0;
            end
        end else begin
            if (beat_tick) begin
                prescale <= '0;
                crotchet <= crotchet + 7'd1;
                if (crotchet == 7'd127) begin
                    looped <= 1'b1;
                end
            end else begin
                prescale <= prescale + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (beat_tick || boot) begin
                        state <= FETCH;
                        voice <= '0;
                        boot  <= 1'b0;
                    end
                end
                FETCH: begin
                    if (fetch_active) begin
                        div[voice]          <= note_div;
                        voice_active[voice] <= 1'b1;
                    end else begin
                        div[voice] <= '0;
                    end
                    if (32'(voice) == VOICES - 1) begin
                        state <= IDLE;
                    end else begin
                        voice <= voice + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // cnt is not cleared on a divider change; the >= compare absorbs a lowered divider.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < VOICES; i++) begin
            if (!rst_n || div[i] == '0) begin
                cnt[i] <= '0;
                sq[i]  <= 1'b0;
            end else if (cnt[i] >= div[i] - 1'b1) begin
                cnt[i] <= '0;
                sq[i]  <= ~sq[i];
            end else begin
                cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    always_comb begin
        ones = '0;
        for (int unsigned i = 0; i < VOICES; i++) begin
            ones = ones + NB'(sq[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            level   <= '0;
            pwm     <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (pwm_cnt == '1) begin
                level <= PWM_BITS'(32'(ones) * STEP);
            end
            pwm <= (pwm_cnt < level);
        end
    end

    assign low_count = cnt[0];

endmodule
